// File: rtl/timer_pkg.sv
// Shared types and default sizes for the reload down-timer.
package timer_pkg;

   localparam int DEF_WIDTH   = 4;
   localparam int DEF_PRESC_W = 4;
   localparam int TC_CNT_W    = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } timer_state_t;

endpackage

// File: rtl/tick_prescaler.sv
// Enable-gated phase counter.
// It emits a tick on the enabled cycle where the phase equals divide, then wraps to 0.
module tick_prescaler #(
   parameter int PRESC_W = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               clear,
   input  logic               enable,
   input  logic [PRESC_W-1:0] divide,
   output logic               tick
);

   logic [PRESC_W-1:0] phase;

   assign tick = enable && (phase == divide);

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         phase <= '0;
      else if (clear)
         phase <= '0;
      else if (enable)
         phase <= tick ? '0 : phase + 1'b1;
   end

endmodule

// File: rtl/reload_down_timer.sv
// Self-reloading down-counter timer with a one-entry shadow register for period updates.
// Optional macro RELOAD_TIMER_TC_COUNT_EN adds a saturating terminal-count tally on tc_cnt_o.
module reload_down_timer
   import timer_pkg::*;
#(
   parameter int WIDTH   = DEF_WIDTH,
   parameter int PRESC_W = DEF_PRESC_W
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               cfg_valid_i,
   output logic               cfg_ready_o,
   input  logic [WIDTH-1:0]   cfg_period_i,
   input  logic               cfg_oneshot_i,
   input  logic [PRESC_W-1:0] presc_i,
   input  logic               start_i,
   input  logic               stop_i,
   input  logic               en_i,
   output logic [WIDTH-1:0]   count_o,
   output logic               tc_o,
   output logic               busy_o
`ifdef RELOAD_TIMER_TC_COUNT_EN
   ,
   output logic [TC_CNT_W-1:0] tc_cnt_o
`endif
);

   timer_state_t     state;
   logic [WIDTH-1:0] count;
   logic             tc;
   logic [WIDTH-1:0] active_p;
   logic             active_oneshot;
   logic [WIDTH-1:0] shadow_p;
   logic             shadow_oneshot;
   logic             pending;

   logic             running;
   logic             accept;
   logic             tick;
   logic             tc_set;
   logic [WIDTH-1:0] idle_p;
   logic             idle_oneshot;

   assign running     = (state == RUN);
   assign accept      = cfg_valid_i && !pending;
   assign cfg_ready_o = !pending;
   assign busy_o      = running;
   assign count_o     = count;
   assign tc_o        = tc;

   // Outside RUN a new write wins over a parked shadow; either becomes the active period.
   assign idle_p       = accept ? cfg_period_i  : (pending ? shadow_p       : active_p);
   assign idle_oneshot = accept ? cfg_oneshot_i : (pending ? shadow_oneshot : active_oneshot);

   assign tc_set = running && !stop_i && !start_i && tick && (count == '0);

   tick_prescaler #(
      .PRESC_W (PRESC_W)
   ) u_prescaler (
      .clk    (clk),
      .reset  (reset),
      .clear  (stop_i || start_i || !running),
      .enable (en_i && running),
      .divide (presc_i),
      .tick   (tick)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state          <= IDLE;
         count          <= '0;
         tc             <= 1'b0;
         active_p       <= '0;
         active_oneshot <= 1'b0;
         shadow_p       <= '0;
         shadow_oneshot <= 1'b0;
         pending        <= 1'b0;
      end else begin
         tc <= tc_set;
         if (running) begin
            if (accept) begin
               shadow_p       <= cfg_period_i;
               shadow_oneshot <= cfg_oneshot_i;
               pending        <= 1'b1;
            end
            if (stop_i) begin
               state <= IDLE;
               count <= active_p;
            end else if (start_i) begin
               count <= active_p;
            end else if (tick) begin
               if (count != '0)
                  count <= count - 1'b1;
               else if (active_oneshot)
                  state <= DONE;
               else if (pending) begin
                  count          <= shadow_p;
                  active_p       <= shadow_p;
                  active_oneshot <= shadow_oneshot;
                  pending        <= 1'b0;
               end else
                  count <= active_p;
            end
         end else begin
            active_p       <= idle_p;
            active_oneshot <= idle_oneshot;
            pending        <= 1'b0;
            // A finished one-shot keeps showing 0 until something new is written or started.
            if (stop_i) begin
               state <= IDLE;
               count <= idle_p;
            end else if (start_i) begin
               state <= RUN;
               count <= idle_p;
            end else if ((state == IDLE) || accept || pending) begin
               count <= idle_p;
            end
         end
      end
   end

`ifdef RELOAD_TIMER_TC_COUNT_EN
   logic [TC_CNT_W-1:0] tc_cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         tc_cnt <= '0;
      else if (start_i && !stop_i && !running)
         tc_cnt <= '0;
      else if (tc_set && (tc_cnt != '1))
         tc_cnt <= tc_cnt + 1'b1;
   end

   assign tc_cnt_o = tc_cnt;
`endif

endmodule

// File: doc/reload_down_timer.md
Name: reload_down_timer

Overview:
Self-reloading down-counter timer: loads a programmed period, decrements once per prescaled tick, and pulses a terminal-count flag on each underflow. On underflow it either reloads (periodic mode) or stops (one-shot mode). It is the down-counting counterpart of the team's up-counting reload counter, and serves as the event/timeout generator for control blocks. Period updates use a valid/ready config handshake with a one-entry shadow register.

Parameters:
WIDTH, 4, bit width of period and count.
PRESC_W, 4, bit width of the prescaler divide value.

Ports:
clk  in  1  clock, rising edge.
reset  in  1  asynchronous, active-high reset.
cfg_valid_i  in  1  config write request.
cfg_ready_o  out  1  config write accepted when valid&ready; equals !pending.
cfg_period_i  in  WIDTH  new period value P.
cfg_oneshot_i  in  1  mode captured with the period: 1 = one-shot, 0 = periodic.
presc_i  in  PRESC_W  tick every presc_i+1 enabled cycles; static while busy.
start_i  in  1  start/restart the timer.
stop_i  in  1  abort to IDLE.
en_i  in  1  run enable; low freezes count and prescaler.
count_o  out  WIDTH  current count, registered.
tc_o  out  1  one-cycle terminal-count pulse, registered.
busy_o  out  1  high in RUN.

Behaviour:
- Reset: state=IDLE; count_o=0, tc_o=0, busy_o=0; active period/mode=0/periodic; shadow=0; pending=0, so cfg_ready_o=1.
- States: IDLE, RUN, DONE.
- Config accept in IDLE or DONE: the active period and mode load the cycle after accept; count_o shows the new P; pending stays 0.
- Config accept in RUN: value goes to shadow; pending=1, so cfg_ready_o=0. The shadow is applied at the next reload; count is not disturbed.
- IDLE/DONE, start_i: next cycle state=RUN, busy_o=1, count_o=active P, prescaler cleared.
- RUN, en_i=1: the prescaler counts 0..presc_i; a tick is the cycle it equals presc_i, then it wraps to 0. presc_i=0 gives a tick every enabled cycle.
- Tick with count>0: count decrements by 1.
- Tick with count==0: tc_o=1 next cycle.
  - Periodic: count reloads to the active P (or to the shadow, if pending, which also becomes active and clears pending).
  - One-shot: state=DONE, busy_o=0, count stays 0.
  - The full period is P+1 ticks. P=0 periodic gives a tc every tick.
- RUN, start_i: restart. Count reloads to the active P, prescaler is cleared, no tc. Pending shadow is not applied.
- stop_i (any state): state=IDLE, count=active P, prescaler cleared, busy=0, no tc. stop_i has priority over start_i and a tick in the same cycle. Pending is kept; it is applied at the next IDLE cycle.
- Config accept in the same cycle as a periodic reload with pending=0: the value goes to shadow; the reload uses the old active P.
- en_i low: no ticks, prescaler and count held. start_i and stop_i still act.
- Count never wraps below 0; all arithmetic is unsigned WIDTH bits.
- Reset asserted mid-run: immediate return to reset values; a tc_o pulse in flight is dropped.

Optional Feature:
Macro RELOAD_TIMER_TC_COUNT_EN.
- Defined: adds output tc_cnt_o (8 bits), which increments on every tc_o pulse and saturates at 255. It clears on reset and on start_i from IDLE/DONE.
- Undefined: no port and no logic; the block is otherwise identical.

Decomposition:
- Package timer_pkg: state enum typedef (IDLE, RUN, DONE), default WIDTH/PRESC_W localparams, TC_CNT_W=8.
- Sub-module tick_prescaler: PRESC_W counter with clear and enable inputs and a tick output.
- The FSM, count register and shadow logic stay in the top module.

Test Plan:
- Reset, cfg P=3 periodic in IDLE, presc=0, start -> count 3,2,1,0,3...; tc_o high every 4 cycles, one cycle wide, coincident with count=3.
- P=2 one-shot, presc=1 -> count drops every 2 cycles; tc_o once after 6 cycles; state DONE, busy_o=0, count_o=0.
- RUN P=5, cfg P=1 mid-count -> cfg_ready_o=0 until reload; the reload loads 1 and later periods are 2 ticks; a second cfg_valid is held off while ready=0.
- en_i low for 3 cycles mid-count -> count and prescaler frozen; resumes from the same value with no tc.
- start_i and stop_i in the same cycle during RUN -> IDLE, count=active P, no tc_o. A later start_i restarts cleanly.
- P=0 periodic, presc=0 -> tc_o high every cycle after the first tick. With RELOAD_TIMER_TC_COUNT_EN, tc_cnt_o reaches 255 and holds.
